// File: rtl/io_sampler_pkg.sv
// Shared definitions for the pin I/O blocks: default pin count, synchroniser
// depth floor and the counter-width helper.
package io_sampler_pkg;

    localparam int IO_NUM_OF_DEFAULT = 10;
    localparam int SYNC_STAGES_MIN   = 2;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-pin synchroniser chain followed by a consecutive-stable-cycles
// debounce filter; exposes the filtered level and its next value.
module io_debounce
    import io_sampler_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic f,
    output logic f_next
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_W  = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              f_reg;
    logic              s;

    assign s = sync_reg[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            cnt_reg  <= '0;
            f_reg    <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], pin};
            cnt_reg  <= cnt_next;
            f_reg    <= f_next;
        end
    end

    // Any cycle where s agrees with the filtered level restarts the count.
    always_comb begin
        f_next   = f_reg;
        cnt_next = cnt_reg;
        if (s == f_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            f_next   = s;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign f = f_reg;

endmodule

// File: rtl/io_sampler.sv
// Samples the shared pins as inputs: per-pin debounce, edge events gathered
// into a sticky pending set drained by a valid/ready handshake.
module io_sampler
    import io_sampler_pkg::*;
#(
    parameter int IO_NUM_OF       = IO_NUM_OF_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic [IO_NUM_OF-1:0] io_pins,
    input  logic [IO_NUM_OF-1:0] in_io_direction,
    input  logic [IO_NUM_OF-1:0] in_rise_en,
    input  logic [IO_NUM_OF-1:0] in_fall_en,
    output logic [IO_NUM_OF-1:0] out_io_inval,
    output logic                 out_event_valid,
    output logic [IO_NUM_OF-1:0] out_event_mask,
    output logic                 out_event_overrun,
    input  logic                 in_event_ready
);

    logic [IO_NUM_OF-1:0] level;
    logic [IO_NUM_OF-1:0] level_next;
    logic [IO_NUM_OF-1:0] new_event;
    logic [IO_NUM_OF-1:0] pending_reg;
    logic [IO_NUM_OF-1:0] pending_next;
    logic                 overrun_reg;
    logic                 overrun_next;
    logic                 acc;

    io_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce [IO_NUM_OF-1:0] (
        .clk    (in_clk),
        .rst    (in_reset),
        .pin    (io_pins),
        .f      (level),
        .f_next (level_next)
    );

    // Pins driven as outputs never raise events; already-pending bits stay.
    assign new_event = ~in_io_direction &
                       ((level_next & ~level & in_rise_en) |
                        (~level_next & level & in_fall_en));

    assign acc = (|pending_reg) & in_event_ready;

    always_comb begin
        pending_next = (acc ? '0 : pending_reg) | new_event;
        overrun_next = overrun_reg;
        if (acc) begin
            overrun_next = 1'b0;
        end else if (|(new_event & pending_reg)) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            pending_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    assign out_io_inval      = level;
    assign out_event_mask    = pending_reg;
    assign out_event_valid   = |pending_reg;
    assign out_event_overrun = overrun_reg;

endmodule

// File: tb/tb_io_sampler.sv
// Randomised and directed checks of io_sampler against a window-based
// reference model of the debounced levels and event set.
module tb_io_sampler;

    localparam int N = 10;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] io_pins;
    logic [N-1:0] dir;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] inval;
    logic         ev_valid;
    logic [N-1:0] ev_mask;
    logic         ev_overrun;
    logic         ev_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: raw pin history (index 0 = newest edge sample).
    logic [N-1:0] pin_hist[$];
    logic [N-1:0] m_level;
    logic [N-1:0] m_pending;
    logic         m_overrun;

    io_sampler #(
        .IO_NUM_OF       (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .in_clk            (clk),
        .in_reset          (rst),
        .io_pins           (io_pins),
        .in_io_direction   (dir),
        .in_rise_en        (rise_en),
        .in_fall_en        (fall_en),
        .out_io_inval      (inval),
        .out_event_valid   (ev_valid),
        .out_event_mask    (ev_mask),
        .out_event_overrun (ev_overrun),
        .in_event_ready    (ev_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pin_hist.delete();
        for (int j = 0; j < S + D; j++) pin_hist.push_back('0);
        m_level   = '0;
        m_pending = '0;
        m_overrun = 1'b0;
    endtask

    // A level is accepted once the pin, seen S edges late, has held a value
    // different from the current level for D consecutive edges.
    task automatic model_edge();
        logic [N-1:0] lv_next;
        logic [N-1:0] nev;
        logic         acc;
        pin_hist.push_front(io_pins);
        void'(pin_hist.pop_back());
        lv_next = m_level;
        for (int i = 0; i < N; i++) begin
            logic v;
            logic stable;
            v = pin_hist[S][i];
            stable = 1'b1;
            for (int j = S; j < S + D; j++) if (pin_hist[j][i] != v) stable = 1'b0;
            if (stable) lv_next[i] = v;
        end
        nev = ~dir & ((lv_next & ~m_level & rise_en) | (~lv_next & m_level & fall_en));
        acc = (m_pending != '0) && ev_ready;
        m_overrun = acc ? 1'b0 : (m_overrun | (|(nev & m_pending)));
        m_pending = (acc ? '0 : m_pending) | nev;
        m_level   = lv_next;
    endtask

    task automatic check_model();
        check_eq("inval",   32'(inval),      32'(m_level));
        check_eq("valid",   32'(ev_valid),   32'(m_pending != '0));
        check_eq("mask",    32'(ev_mask),    32'(m_pending));
        check_eq("overrun", 32'(ev_overrun), 32'(m_overrun));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_model();
        end
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mask",  32'(ev_mask),  32'd0);
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        check_eq("rst_inval", 32'(inval),    32'd0);
        check_eq("rst_ovr",   32'(ev_overrun), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        io_pins  = '0;
        dir      = '0;
        rise_en  = '0;
        fall_en  = '0;
        ev_ready = 1'b0;
        model_reset();
        #1;
        check_eq("reset_valid", 32'(ev_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle: nothing moves.
        tick(20);
        check_eq("idle_mask", 32'(ev_mask), 32'd0);

        // Pin 3 rise: event visible exactly S+D edges later.
        rise_en = '1;
        io_pins[3] = 1'b1;
        tick(S + D - 1);
        check_eq("p3_early_mask", 32'(ev_mask), 32'd0);
        tick(1);
        check_eq("p3_mask",  32'(ev_mask),  32'h008);
        check_eq("p3_valid", 32'(ev_valid), 32'd1);
        check_eq("p3_inval", 32'(inval[3]), 32'd1);
        drain();
        check_eq("p3_drained", 32'(ev_mask), 32'd0);

        // Short pulse filtered; full-length pulse gives rise then fall.
        io_pins[0] = 1'b1; tick(D - 1);
        io_pins[0] = 1'b0; tick(10);
        check_eq("glitch_inval0", 32'(inval[0]), 32'd0);
        check_eq("glitch_mask",   32'(ev_mask),  32'd0);
        fall_en[0] = 1'b1;
        io_pins[0] = 1'b1; tick(D);
        io_pins[0] = 1'b0; tick(S + D);
        check_eq("pulse_ovr", 32'(ev_overrun), 32'd1);
        drain();
        tick(4);

        // Output-direction pin: level tracked, event suppressed.
        dir[5] = 1'b1;
        io_pins[5] = 1'b1; tick(S + D + 2);
        check_eq("dir_inval5", 32'(inval[5]), 32'd1);
        check_eq("dir_mask",   32'(ev_mask),  32'd0);
        dir[5] = 1'b0; fall_en[5] = 1'b1;
        io_pins[5] = 1'b0; tick(S + D + 2);
        check_eq("dir_fall_mask", 32'(ev_mask), 32'h020);
        drain();

        // Overrun: second edge on a still-pending pin.
        io_pins[1] = 1'b1; tick(S + D + 2);
        fall_en[1] = 1'b1;
        io_pins[1] = 1'b0; tick(S + D + 2);
        check_eq("ovr_flag", 32'(ev_overrun), 32'd1);
        check_eq("ovr_mask", 32'(ev_mask),    32'h002);
        drain();
        check_eq("ovr_clr",  32'(ev_overrun), 32'd0);
        check_eq("ovr_mask_clr", 32'(ev_mask), 32'd0);

        // New event arriving on the drain cycle survives the drain.
        fall_en = '0;
        io_pins[0] = 1'b1; tick(S + D);
        check_eq("pre_drain_mask", 32'(ev_mask), 32'h001);
        io_pins[2] = 1'b1; tick(S + D - 1);
        drain();
        check_eq("survive_mask",  32'(ev_mask),  32'h004);
        check_eq("survive_valid", 32'(ev_valid), 32'd1);
        drain();

        // Four simultaneous edges, then asynchronous reset wipes them.
        fall_en = '1;
        io_pins[3:0] = 4'b0010;
        tick(S + D);
        check_eq("four_mask", 32'(ev_mask), 32'h00F);
        async_reset();
        check_eq("post_rst_mask", 32'(ev_mask), 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) io_pins[i] = ~io_pins[i];
            if ($urandom_range(31) == 0) dir     = N'($urandom);
            if ($urandom_range(31) == 0) rise_en = N'($urandom);
            if ($urandom_range(31) == 0) fall_en = N'($urandom);
            ev_ready = ($urandom_range(3) == 0);
            if (c == 1500) async_reset();
            tick(1);
        end
        ev_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_sampler.md
Name: io_sampler

Overview:
- Input-side counterpart of the pin bitbang block: samples the shared `io_pins` as inputs and reports their state and change events to the controller.
- Per pin it synchronises, debounces and edge-detects the pin.
- Edge events are accumulated into a sticky pending set, which the controller drains through a valid/ready handshake.
- Pins currently configured as outputs by the controller generate no events.

Parameters:
- IO_NUM_OF, 10, number of pins sampled.
- SYNC_STAGES, 2, synchroniser flops per pin; must be >= 2.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a new level; must be >= 1.

Ports:
- in_clk  input  1  the single clock.
- in_reset  input  1  asynchronous, active-high reset.
- io_pins  input  IO_NUM_OF  raw pin levels, asynchronous to in_clk.
- in_io_direction  input  IO_NUM_OF  1 = pin driven as output; its events are suppressed.
- in_rise_en  input  IO_NUM_OF  enable rising-edge events per pin.
- in_fall_en  input  IO_NUM_OF  enable falling-edge events per pin.
- out_io_inval  output  IO_NUM_OF  debounced pin levels.
- out_event_valid  output  1  at least one event is pending.
- out_event_mask  output  IO_NUM_OF  pending event bits, one per pin.
- out_event_overrun  output  1  an event was lost since the last drain.
- in_event_ready  input  1  controller accepts the current mask.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, debounced levels, counters, pending bits and overrun are cleared. All outputs read 0.
- Synchroniser: SYNC_STAGES-flop chain per pin. Its output is `s[i]`.
- Debounce (per pin):
  - Holds a counter of width `clog2(DEBOUNCE_CYCLES)`, minimum 1 bit, and the filtered level `f[i]`.
  - If `s == f`: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: `f <= s`, counter <= 0.
  - Else: counter <= counter+1.
  - Any glitch back to `f` restarts the count.
  - A level stable at `s` from cycle t appears on `f` at cycle t+DEBOUNCE_CYCLES.
  - Pin-to-`out_io_inval` latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - With DEBOUNCE_CYCLES=1, `f` follows `s` with one cycle of delay.
- out_io_inval = f, for every pin regardless of direction.
- Edge event (per pin, combinational in the cycle `f` changes, registered into pending):
  - `new[i] = ~in_io_direction[i] & ((f_next & ~f & in_rise_en[i]) | (~f_next & f & in_fall_en[i]))`.
  - The direction and enable inputs are sampled in that same cycle.
- Handshake: `acc = out_event_valid & in_event_ready`.
- Pending register (registered):
  - `pending <= (pending & ~(acc ? pending : 0)) | new`.
  - A new event on the drain cycle survives the drain.
  - out_event_mask = pending.
  - out_event_valid = |pending. It is registered-equivalent: no combinational path from in_event_ready.
  - in_event_ready while not valid has no effect.
- Overrun:
  - Set when `new[i] & pending[i] & ~acc` for any i, i.e. a second edge on a pin whose bit is still pending.
  - On acc, overrun <= (new-event-on-already-pending condition evaluated as if not accepted)? No: on acc, overrun <= 0. It is reported alongside the mask being drained.
  - A drained mask carries any overrun accumulated before the drain.
- Direction change while a bit is pending: the bit is retained until drained. Suppression only affects new events.
- Enables and direction changing mid-debounce do not reset counters.
- Reset mid-operation: everything clears immediately, pending events are lost, and valid drops asynchronously.

Decomposition:
- Shared io package holds:
  - the default IO_NUM_OF,
  - the minimum SYNC_STAGES constant,
  - a clog2 function for the counter width, shared with any later pin blocks.
- One sub-module, `io_debounce`: a single-pin synchroniser plus debounce counter plus filtered-level register.
  - It exposes `f` and `f_next`.
  - It is instantiated IO_NUM_OF times as an instance array.
- Event, pending and overrun logic stays in io_sampler.

Test Plan:
- Reset, then io_pins=0 and all enables 0 for 20 cycles -> out_io_inval=0, out_event_valid=0, out_event_mask=0, out_event_overrun=0.
- Defaults, in_rise_en=all ones, direction=0, pin 3 goes 0->1 at cycle 0 and holds -> out_io_inval[3]=1 and out_event_mask=0x008 with out_event_valid=1 visible at cycle 6 (pin change to event is SYNC_STAGES+DEBOUNCE_CYCLES); in_event_ready=1 for one cycle -> mask returns to 0.
- Pin 0 pulse high for 3 cycles (less than DEBOUNCE_CYCLES) -> out_io_inval[0] stays 0, no event; a 4-cycle pulse -> exactly one rise event, then one fall event only if in_fall_en[0]=1.
- Pin 5 rises while in_io_direction[5]=1 -> out_io_inval[5]=1, no event; direction set to 0 then pin falls with fall enabled -> mask=0x020.
- Pin 1 rises and is left pending, then pin 1 falls with fall enabled and no ready -> out_event_overrun=1, mask=0x002; drain -> overrun=0, mask=0.
- Drain the mask 0x001 with ready=1 in the same cycle pin 2's debounced edge fires -> next cycle mask=0x004 and valid=1.
- Assert in_reset with mask=0x00F pending -> mask=0 and valid=0 immediately.
